// File: rtl/af_sweep_ctrl.sv
// Autofocus coarse-then-fine lens sweep: steps the VCM over REQ/ACK, skips settle frames,
// tracks the sharpest step and parks the lens there. Define AF_EARLY_STOP_EN for early coarse exit.
module af_sweep_ctrl #(
  parameter int unsigned COARSE_INC    = 64,
  parameter int unsigned FINE_INC      = 4,
  parameter int unsigned MAX_STEP      = 1023,
`ifdef AF_EARLY_STOP_EN
  parameter int unsigned DROP_COUNT    = 3,
`endif
  parameter int unsigned SETTLE_FRAMES = 2
) (
  input  logic        i_video_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_focus_valid,
  input  logic [31:0] i_focus_sum,
  input  logic        i_step_ack,
  output logic [9:0]  o_step,
  output logic        o_step_req,
  output logic        o_busy,
  output logic        o_done,
  output logic [9:0]  o_best_step,
  output logic [31:0] o_peak_sum
);

  typedef enum logic [2:0] {
    StIdle, StMove, StSettle, StMeasure, StFineInit, StPark, StFinish
  } state_e;

  typedef enum logic {PhCoarse, PhFine} phase_e;

  localparam int unsigned      SettleW    = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_FRAMES - 1);
  localparam logic [10:0]      CoarseInc11 = 11'(COARSE_INC);
  localparam logic [10:0]      FineInc11   = 11'(FINE_INC);
  localparam logic [10:0]      MaxStep11   = 11'(MAX_STEP);
  localparam logic [9:0]       MaxStep10   = 10'(MAX_STEP);
  localparam logic signed [11:0] CoarseIncS = 12'(COARSE_INC);

  state_e               r_state, w_state_nxt;
  phase_e               r_phase, w_phase_nxt;
  logic [9:0]           r_step, w_step_nxt;
  logic                 r_req, w_req_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic [9:0]           r_best, w_best_nxt;
  logic [31:0]          r_peak, w_peak_nxt;
  logic [9:0]           r_hi, w_hi_nxt;
  logic [SettleW-1:0]   r_settle_cnt, w_settle_cnt_nxt;

  logic                 w_ack;
  logic                 w_better;
  logic                 w_settle_last;
  logic [10:0]          w_inc;
  logic [10:0]          w_nxt_step;
  logic [10:0]          w_bound;
  logic                 w_in_range;
  logic signed [11:0]   w_lo_s;
  logic [9:0]           w_lo;
  logic [10:0]          w_hi_sum;
  logic [9:0]           w_hi;
  logic                 w_early_stop;

  // ACK only counts while a request is outstanding.
  assign w_ack         = i_step_ack & r_req;
  assign w_better      = i_focus_sum > r_peak;
  assign w_settle_last = (r_settle_cnt == SettleLast);
  assign w_inc         = (r_phase == PhCoarse) ? CoarseInc11 : FineInc11;
  assign w_nxt_step    = {1'b0, r_step} + w_inc;
  assign w_bound       = (r_phase == PhCoarse) ? MaxStep11 : {1'b0, r_hi};
  assign w_in_range    = (w_nxt_step <= w_bound);

  // Fine window around the coarse winner, clamped to the legal step range.
  assign w_lo_s   = $signed({2'b00, r_best}) - CoarseIncS;
  assign w_lo     = (w_lo_s < 12'sd0) ? 10'd0 : w_lo_s[9:0];
  assign w_hi_sum = {1'b0, r_best} + CoarseInc11;
  assign w_hi     = (w_hi_sum > MaxStep11) ? MaxStep10 : w_hi_sum[9:0];

`ifdef AF_EARLY_STOP_EN
  localparam int unsigned      DropW    = (DROP_COUNT > 1) ? $clog2(DROP_COUNT + 1) : 1;
  localparam logic [DropW-1:0] DropLast = DropW'(DROP_COUNT);

  logic [31:0]      r_prev_sum;
  logic [DropW-1:0] r_drop_cnt;
  logic [DropW-1:0] w_drop_nxt;
  logic             w_coarse_meas;

  assign w_coarse_meas = (r_state == StMeasure) && i_focus_valid && (r_phase == PhCoarse) &&
                         !i_abort;
  assign w_drop_nxt    = (i_focus_sum < r_prev_sum) ? r_drop_cnt + 1'b1 : '0;
  assign w_early_stop  = (r_phase == PhCoarse) && (w_drop_nxt == DropLast);

  always_ff @(posedge i_video_clk) begin
    if (i_reset) begin
      r_prev_sum <= '0;
      r_drop_cnt <= '0;
    end else if (r_state == StIdle && i_start && !i_abort) begin
      r_prev_sum <= '0;
      r_drop_cnt <= '0;
    end else if (w_coarse_meas) begin
      r_prev_sum <= i_focus_sum;
      r_drop_cnt <= w_drop_nxt;
    end
  end
`else
  assign w_early_stop = 1'b0;
`endif

  always_ff @(posedge i_video_clk) begin
    if (i_reset) begin
      r_state      <= StIdle;
      r_phase      <= PhCoarse;
      r_step       <= '0;
      r_req        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_best       <= '0;
      r_peak       <= '0;
      r_hi         <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_phase      <= w_phase_nxt;
      r_step       <= w_step_nxt;
      r_req        <= w_req_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_best       <= w_best_nxt;
      r_peak       <= w_peak_nxt;
      r_hi         <= w_hi_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = StIdle;
    end else begin
      unique case (r_state)
        StIdle:     if (i_start) w_state_nxt = StMove;
        StMove:     if (w_ack) w_state_nxt = (SETTLE_FRAMES == 0) ? StMeasure : StSettle;
        StSettle:   if (i_focus_valid && w_settle_last) w_state_nxt = StMeasure;
        StMeasure: begin
          if (i_focus_valid) begin
            if (w_early_stop)            w_state_nxt = StFineInit;
            else if (w_in_range)         w_state_nxt = StMove;
            else if (r_phase == PhCoarse) w_state_nxt = StFineInit;
            else                         w_state_nxt = StPark;
          end
        end
        StFineInit: w_state_nxt = StMove;
        StPark:     if (w_ack) w_state_nxt = StFinish;
        StFinish:   w_state_nxt = StIdle;
        default:    w_state_nxt = StIdle;
      endcase
    end
  end

  always_comb begin
    w_phase_nxt      = r_phase;
    w_step_nxt       = r_step;
    w_best_nxt       = r_best;
    w_peak_nxt       = r_peak;
    w_hi_nxt         = r_hi;
    w_settle_cnt_nxt = r_settle_cnt;
    if (!i_abort) begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            w_phase_nxt = PhCoarse;
            w_step_nxt  = '0;
            w_best_nxt  = '0;
            w_peak_nxt  = '0;
          end
        end
        StMove:   if (w_ack) w_settle_cnt_nxt = '0;
        StSettle: if (i_focus_valid) w_settle_cnt_nxt = r_settle_cnt + 1'b1;
        StMeasure: begin
          if (i_focus_valid) begin
            if (w_better) begin
              w_peak_nxt = i_focus_sum;
              w_best_nxt = r_step;
            end
            // Parking uses the winner including this last measurement.
            if (w_state_nxt == StMove)      w_step_nxt = w_nxt_step[9:0];
            else if (w_state_nxt == StPark) w_step_nxt = w_best_nxt;
          end
        end
        StFineInit: begin
          w_step_nxt  = w_lo;
          w_hi_nxt    = w_hi;
          w_peak_nxt  = '0;
          w_phase_nxt = PhFine;
        end
        StPark, StFinish: ;
        default: ;
      endcase
    end
  end

  assign w_req_nxt  = (w_state_nxt == StMove) || (w_state_nxt == StPark);
  assign w_busy_nxt = (w_state_nxt != StIdle) && (w_state_nxt != StFinish);
  assign w_done_nxt = (w_state_nxt == StFinish);

  assign o_step      = r_step;
  assign o_step_req  = r_req;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_best_step = r_best;
  assign o_peak_sum  = r_peak;

endmodule

// File: tb/tb_af_sweep_ctrl.sv
// Directed bench for af_sweep_ctrl: a VCM/frame responder acks steps and feeds sharpness sums,
// a scoreboard queue holds the step sequence each sweep must request.
`timescale 1ns/1ps
module tb_af_sweep_ctrl;

  localparam int CoarseInc    = 64;
  localparam int FineInc      = 4;
  localparam int MaxStep      = 1023;
  localparam int SettleFrames = 2;
  localparam int DropCount    = 3;
  localparam int FramePeriod  = 8;
  localparam int Budget       = 6000;

  logic        clk = 1'b0;
  logic        rst, start, abort, focus_valid, step_ack;
  logic [31:0] focus_sum;
  logic [9:0]  step, best_step;
  logic        step_req, busy, done;
  logic [31:0] peak_sum;

  always #5 clk = ~clk;

  af_sweep_ctrl dut (
    .i_video_clk   (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_abort       (abort),
    .i_focus_valid (focus_valid),
    .i_focus_sum   (focus_sum),
    .i_step_ack    (step_ack),
    .o_step        (step),
    .o_step_req    (step_req),
    .o_busy        (busy),
    .o_done        (done),
    .o_best_step   (best_step),
    .o_peak_sum    (peak_sum)
  );

  int n_pass  = 0;
  int n_total = 0;
  int q_exp[$];
  int peak_pos   = 0;
  int slope      = 0;
  int ack_delay  = 3;
  int delay_once = 0;
  bit env_en     = 1'b0;
  int acks_seen  = 0;
  int done_seen  = 0;
  bit unstable   = 1'b0;
  int exp_best   = 0;
  int exp_peak   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  function automatic int sum_of(input int s);
    int d;
    d = (s > peak_pos) ? s - peak_pos : peak_pos - s;
    return 100000 - d * slope;
  endfunction

  // Reference sweep: coarse points, clamped fine window, then the park step.
  function automatic int build_model();
    int best, lo, hi, n, pk, v;
`ifdef AF_EARLY_STOP_EN
    int prev, drops;
    prev  = 0;
    drops = 0;
`endif
    q_exp.delete();
    best = 0;
    pk   = 0;
    n    = 0;
    for (int s = 0; s <= MaxStep; s += CoarseInc) begin
      q_exp.push_back(s);
      n++;
      v = sum_of(s);
      if (v > pk) begin pk = v; best = s; end
`ifdef AF_EARLY_STOP_EN
      drops = (v < prev) ? drops + 1 : 0;
      prev  = v;
      if (drops == DropCount) break;
`endif
    end
    lo = best - CoarseInc;
    if (lo < 0) lo = 0;
    hi = best + CoarseInc;
    if (hi > MaxStep) hi = MaxStep;
    pk = 0;
    for (int s = lo; s <= hi; s += FineInc) begin
      q_exp.push_back(s);
      n++;
      v = sum_of(s);
      if (v > pk) begin pk = v; best = s; end
    end
    q_exp.push_back(best);
    n++;
    exp_best = best;
    exp_peak = pk;
    return n;
  endfunction

  // VCM writer + frame source; drives 1 time unit after each rising edge.
  task automatic env_loop();
    int         req_run = 0, frames = 0, cyc = 0, dly, exp_step;
    bit         armed = 0, req_prev = 0, ack_prev = 0, s_rst, s_abort;
    logic [9:0] step_prev = '0;
    forever begin
      @(posedge clk);
      s_rst   = rst;
      s_abort = abort;
      if (step_ack) begin
        acks_seen++;
        frames = 0;
        armed  = 1;
      end else if (focus_valid && armed) begin
        frames++;
      end
      #1;
      if (done) done_seen++;
      if (req_prev && step_req && step != step_prev) unstable = 1;
      if (req_prev && !step_req && !ack_prev && !s_rst && !s_abort) unstable = 1;
      if (!req_prev && step_req && armed) begin
        check("settle_frames", 32'(frames), 32'(SettleFrames + 1));
        armed = 0;
      end
      if (!busy) armed = 0;
      step_ack    = 1'b0;
      focus_valid = 1'b0;
      if (step_req && env_en) begin
        req_run++;
        dly = (delay_once > 0) ? delay_once : ack_delay;
        if (req_run >= dly) begin
          check("sb_pending", 32'(q_exp.size() > 0), 32'd1);
          if (q_exp.size() > 0) begin
            exp_step = q_exp.pop_front();
            check("sb_step", 32'(step), 32'(exp_step));
          end
          step_ack   = 1'b1;
          req_run    = 0;
          delay_once = 0;
        end
      end else begin
        req_run = 0;
      end
      cyc++;
      if (cyc % FramePeriod == 0) begin
        focus_valid = 1'b1;
        focus_sum   = 32'(sum_of(int'(step)));
      end
      step_prev = step;
      req_prev  = step_req;
      ack_prev  = step_ack;
    end
  endtask

  task automatic run_sweep(input string tag, input int poke_at);
    int n_exp, acks0, done0;
    bit poked;
    n_exp    = build_model();
    acks0    = acks_seen;
    done0    = done_seen;
    unstable = 1'b0;
    poked    = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < Budget; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) break;
      if (poke_at > 0 && !poked && acks_seen - acks0 >= poke_at) begin
        start = 1'b1;
        poked = 1'b1;
      end
    end
    start = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_best"}, 32'(best_step), 32'(exp_best));
    check({tag, "_peak"}, peak_sum, 32'(exp_peak));
    check({tag, "_park_step"}, 32'(step), 32'(exp_best));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_acks"}, 32'(acks_seen - acks0), 32'(n_exp));
    check({tag, "_sb_drained"}, 32'(q_exp.size()), 32'd0);
    check({tag, "_req_stable"}, 32'(unstable), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done_seen - done0), 32'd1);
    check({tag, "_done_low"}, 32'(done), 32'd0);
  endtask

  initial begin
    int acks0, done0, i;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    focus_valid = 1'b0; focus_sum = '0; step_ack = 1'b0;
    fork env_loop(); join_none
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_step", 32'(step), 32'd0);
    check("rst_req", 32'(step_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_best", 32'(best_step), 32'd0);
    check("rst_peak", peak_sum, 32'd0);
    env_en = 1'b1;

    // Peak at 320; a stray START mid-sweep must be ignored.
    peak_pos = 320; slope = 100;
    acks0 = acks_seen;
    run_sweep("peak320", 10);
    check("peak320_best_const", 32'(best_step), 32'd320);
    check("peak320_peak_const", peak_sum, 32'd100000);
`ifndef AF_EARLY_STOP_EN
    check("peak320_ack_total", 32'(acks_seen - acks0), 32'd50);
`endif

    peak_pos = 1000; slope = 50;
    run_sweep("peak1000", 0);
    check("peak1000_best_const", 32'(best_step), 32'd1000);

    peak_pos = 0; slope = 100;
    run_sweep("peak0", 0);
    check("peak0_best_const", 32'(best_step), 32'd0);

    // Flat response with the first ACK held back 50 cycles while frames keep arriving.
    peak_pos = 500; slope = 0;
    delay_once = 50;
    run_sweep("flat", 0);
    check("flat_best_const", 32'(best_step), 32'd0);

    // Abort in the settle window of the 5th coarse point.
    peak_pos = 320; slope = 100;
    void'(build_model());
    acks0 = acks_seen;
    done0 = done_seen;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (i = 0; i < Budget && acks_seen - acks0 < 5; i++) @(negedge clk);
    check("abort_reached_5th", 32'(acks_seen - acks0), 32'd5);
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_req", 32'(step_req), 32'd0);
    check("abort_step_hold", 32'(step), 32'd256);
    check("abort_best_hold", 32'(best_step), 32'd192);
    check("abort_peak_hold", peak_sum, 32'd87200);
    repeat (20) @(negedge clk);
    check("abort_stays_idle", 32'(busy), 32'd0);
    check("abort_no_done", 32'(done_seen - done0), 32'd0);
    q_exp.delete();
    run_sweep("restart", 0);

`ifdef AF_EARLY_STOP_EN
    peak_pos = 128; slope = 100;
    run_sweep("early", 0);
    check("early_best_const", 32'(best_step), 32'd128);
`endif

    // Synchronous reset while a step request is outstanding.
    peak_pos = 320; slope = 100;
    void'(build_model());
    acks0 = acks_seen;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (i = 0; i < Budget && acks_seen - acks0 < 3; i++) @(negedge clk);
    for (i = 0; i < Budget && !step_req; i++) @(negedge clk);
    check("rst_mid_in_move", 32'(step_req), 32'd1);
    check("rst_mid_best_before", 32'(best_step), 32'd128);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check("rst_mid_step", 32'(step), 32'd0);
    check("rst_mid_req", 32'(step_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_best", 32'(best_step), 32'd0);
    check("rst_mid_peak", peak_sum, 32'd0);
    q_exp.delete();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/af_sweep_ctrl.md
Name: af_sweep_ctrl

Overview:
- Autofocus search sequencer for the VCM focus path.
- Drives a coarse-then-fine lens step sweep, issues each step to the VCM write path over a REQ/ACK handshake, waits for settle frames, and samples the per-frame sharpness sum.
- Ends by parking the lens at the sharpest step.
- Sits between the sharpness accumulator (sum updated once per frame) and the VCM I2C writer.

Parameters:
- COARSE_INC, 64, coarse sweep step increment.
- FINE_INC, 4, fine sweep step increment.
- MAX_STEP, 1023, highest legal VCM step (10-bit).
- SETTLE_FRAMES, 2, frames discarded after each move before measuring (0 allowed).
- DROP_COUNT, 3, consecutive falling measurements that end the coarse phase (only used with the optional feature).

Ports:
- VIDEO_CLK  in  1  sole clock.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a sweep when idle.
- ABORT  in  1  level/pulse; cancels the sweep.
- FOCUS_VALID  in  1  one-cycle pulse per frame; FOCUS_SUM is valid.
- FOCUS_SUM  in  32  sharpness sum of the last frame.
- STEP_ACK  in  1  VCM writer has accepted STEP.
- STEP  out  10  lens step being requested/held.
- STEP_REQ  out  1  request to write STEP.
- BUSY  out  1  high from accepted START until DONE or ABORT.
- DONE  out  1  one-cycle pulse when the lens is parked.
- BEST_STEP  out  10  step with the highest sum in the last fine phase.
- PEAK_SUM  out  32  sum at BEST_STEP.

Behaviour:
- One clock: VIDEO_CLK. Reset is synchronous and active-high on RESET.
- Reset values: STEP=0, STEP_REQ=0, BUSY=0, DONE=0, BEST_STEP=0, PEAK_SUM=0, state=IDLE, phase=COARSE.
- RESET mid-sweep returns to these values on the next edge. Any outstanding REQ is dropped.
- States: IDLE, MOVE, SETTLE, MEASURE, FINE_INIT, PARK, FINISH.
- IDLE:
  - START -> clear PEAK_SUM/BEST_STEP, set phase=COARSE, STEP=0, go to MOVE, BUSY=1 the next cycle.
  - START while BUSY is ignored.
- MOVE:
  - STEP_REQ=1 and STEP held stable until a cycle with STEP_ACK=1.
  - In that cycle REQ drops the next edge, settle counter=0, go to SETTLE (or MEASURE if SETTLE_FRAMES=0).
  - STEP_ACK while REQ=0 is ignored. FOCUS_VALID in MOVE is ignored.
- SETTLE: count FOCUS_VALID pulses. On the SETTLE_FRAMES-th pulse go to MEASURE; that frame's sum is not used.
- MEASURE: on the next FOCUS_VALID compare FOCUS_SUM with PEAK_SUM, unsigned.
  - Strictly greater updates PEAK_SUM/BEST_STEP. A tie keeps the earlier step.
  - Next step is computed 11-bit wide: nxt = STEP + INC for the current phase.
  - If nxt <= phase upper bound: STEP=nxt, go to MOVE.
  - Otherwise: COARSE goes to FINE_INIT; FINE goes to PARK.
  - COARSE upper bound = MAX_STEP.
- FINE_INIT (1 cycle):
  - lo = max(0, BEST_STEP - COARSE_INC), computed signed, no wrap.
  - hi = min(MAX_STEP, BEST_STEP + COARSE_INC).
  - Clear PEAK_SUM to 0. STEP=lo, phase=FINE, go to MOVE.
- PARK:
  - STEP=BEST_STEP, REQ/ACK exactly as in MOVE.
  - On ACK go to FINISH. No settle wait.
- FINISH: DONE=1 for one cycle, BUSY=0, go to IDLE. STEP holds BEST_STEP.
- ABORT (any non-IDLE state) -> IDLE the next edge.
  - STEP_REQ=0, BUSY=0, no DONE.
  - STEP, BEST_STEP and PEAK_SUM hold.
  - ABORT has priority over START and ACK in the same cycle.
- Simultaneous STEP_ACK and FOCUS_VALID in MOVE: take the ACK; the frame is not counted.
- Default coarse points: 0, 64, ..., 960 (16 points).

Optional Feature:
- Macro AF_EARLY_STOP_EN.
- Defined:
  - During COARSE, a measurement strictly below the previous coarse measurement increments a drop counter; any other result clears it.
  - When the counter reaches DROP_COUNT, go to FINE_INIT immediately, with the remaining coarse points skipped.
  - The counter clears on START.
- Not defined: the full coarse range is always swept; no counter logic is generated.

Test Plan:
- Defaults, no early stop. Bench acks after 3 cycles and returns sum = 100000 - |step-320|*100 per frame -> coarse best 320; fine sweep 256..384 step 4; DONE pulse; STEP=BEST_STEP=320, PEAK_SUM=100000; total ACKs = 16+33+1 = 50.
- Peak at step 1000 (sum decreasing from 1000) -> coarse best 960; fine hi clipped to 1023, last fine point 1020; BEST_STEP=1000; no STEP value above 1023 ever driven.
- Peak at step 0 -> fine lo clipped to 0 (no wrap to 960+), fine points 0..64; BEST_STEP=0.
- Equal sums everywhere -> BEST_STEP = first fine point; STEP_ACK withheld 50 cycles with FOCUS_VALID pulses meanwhile -> REQ and STEP stay stable, those frames are not counted.
- ABORT during the 5th coarse SETTLE -> next edge BUSY=0, REQ=0, no DONE; START then restarts from STEP=0. RESET mid-MOVE -> all outputs reach reset values in one cycle.
- AF_EARLY_STOP_EN defined, peak at 128 -> coarse stops after measuring 320 (3 drops: 192, 256, 320); fine 64..192; BEST_STEP=128.
